// File: rtl/launch_pkg.sv
// Shared entry layout, widths and helpers for the multi-issue launch stage.
// Entry bit order (MSB first): pc, payload, we, waddr, re1, raddr1, re2, raddr2, excl, jmp, jmp_addr.
package launch_pkg;

    localparam int PcWidth       = 32;
    localparam int RegsAddrWidth = 5;

    // Low-order fields of every entry; the payload and pc sit above them.
    typedef struct packed {
        logic                     we;
        logic [RegsAddrWidth-1:0] waddr;
        logic                     re1;
        logic [RegsAddrWidth-1:0] raddr1;
        logic                     re2;
        logic [RegsAddrWidth-1:0] raddr2;
        logic                     excl;
        logic                     jmp;
        logic [PcWidth-1:0]       jmp_addr;
    } ctrl_t;

    localparam int CtrlWidth = $bits(ctrl_t);

    function automatic int entry_w(input int payload_w);
        return PcWidth + payload_w + CtrlWidth;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned popcnt(input logic [7:0] v);
        int unsigned n = 0;
        for (int unsigned i = 0; i < 8; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/issue_select.sv
// Combinational slot-rule chain: forms the in-order issue group from the head entries.
module issue_select
    import launch_pkg::*;
#(
    parameter int ISSUE_W = 2
) (
    input  logic [ISSUE_W-1:0]  present,
    input  ctrl_t [ISSUE_W-1:0] ctrl,
    output logic [ISSUE_W-1:0]  issue,
    output logic                jmp_hit,
    output logic [PcWidth-1:0]  jmp_addr
);

    always_comb begin
        logic prev_ok;
        logic raw;
        issue    = '0;
        jmp_hit  = 1'b0;
        jmp_addr = '0;
        prev_ok  = 1'b1;
        raw      = 1'b0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            raw = 1'b0;
            for (int unsigned j = 0; j < k; j++) begin
                if (ctrl[j].we && (ctrl[j].waddr != '0) &&
                    ((ctrl[k].re1 && (ctrl[k].raddr1 == ctrl[j].waddr)) ||
                     (ctrl[k].re2 && (ctrl[k].raddr2 == ctrl[j].waddr))))
                    raw = 1'b1;
            end
            // jmp_hit doubles as "an older slot in this group is a taken jump"
            issue[k] = prev_ok && present[k] && !jmp_hit && !raw && !((k != 0) && ctrl[k].excl);
            prev_ok  = issue[k];
            if (issue[k] && ctrl[k].jmp) begin
                jmp_hit  = 1'b1;
                jmp_addr = ctrl[k].jmp_addr;
            end
        end
    end

endmodule

// File: rtl/multi_issue_launch.sv
// Circular instruction buffer with ISSUE_W-wide push and in-order group issue toward EX.
// Optional LAUNCH_PERF_CNT_EN adds full-issue and stall cycle counters.
module multi_issue_launch
    import launch_pkg::*;
#(
    parameter  int ISSUE_W   = 2,
    parameter  int DEPTH     = 8,
    parameter  int PAYLOAD_W = 64,
    localparam int ENTRY_W   = entry_w(PAYLOAD_W)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ISSUE_W-1:0]              in_valid_i,
    input  logic [ISSUE_W-1:0][ENTRY_W-1:0] in_entry_i,
    output logic                            in_ready_o,
    input  logic                            next_allowin_i,
    input  logic                            excep_flush_i,
    output logic [ISSUE_W-1:0]              out_valid_o,
    output logic [ISSUE_W-1:0][ENTRY_W-1:0] out_entry_o,
    output logic                            jmp_flag_o,
    output logic [PcWidth-1:0]              jmp_addr_o
`ifdef LAUNCH_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_full_issue_cnt_o,
    output logic [31:0]                     perf_stall_cnt_o
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [ENTRY_W-1:0]         mem [DEPTH];
    logic [PW-1:0]              head, tail, count, free_cnt, n_push, n_pop;
    logic [ISSUE_W-1:0][AW-1:0] rd_idx;
    logic [ISSUE_W-1:0]         present, issue;
    ctrl_t [ISSUE_W-1:0]        ctrl;
    logic                       sel_jmp_hit, do_pop, branch;
    logic [PcWidth-1:0]         sel_jmp_addr;

    assign count      = tail - head;
    assign free_cnt   = PW'(DEPTH) - count;
    assign in_ready_o = free_cnt >= PW'(ISSUE_W);

    always_comb begin
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            rd_idx[k]      = AW'(head + PW'(k));
            out_entry_o[k] = mem[rd_idx[k]];
            present[k]     = PW'(k) < count;
            ctrl[k]        = out_entry_o[k][CtrlWidth-1:0];
        end
    end

    issue_select #(.ISSUE_W(ISSUE_W)) u_issue_select (
        .present  (present),
        .ctrl     (ctrl),
        .issue    (issue),
        .jmp_hit  (sel_jmp_hit),
        .jmp_addr (sel_jmp_addr)
    );

    assign do_pop      = next_allowin_i && !excep_flush_i;
    assign branch      = do_pop && sel_jmp_hit;
    assign out_valid_o = excep_flush_i ? '0 : issue;
    assign jmp_flag_o  = branch;
    assign jmp_addr_o  = branch ? sel_jmp_addr : '0;
    assign n_pop       = do_pop ? PW'(popcnt(8'(issue))) : '0;
    assign n_push      = in_ready_o ? PW'(popcnt(8'(in_valid_i))) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (excep_flush_i) begin
            tail <= head;
        end else if (branch) begin
            // everything younger than the jump is wrong-path; this cycle's push too
            head <= head + n_pop;
            tail <= head + n_pop;
        end else begin
            head <= head + n_pop;
            tail <= tail + n_push;
            if (in_ready_o) begin
                for (int unsigned k = 0; k < ISSUE_W; k++)
                    if (in_valid_i[k]) mem[AW'(tail + PW'(k))] <= in_entry_i[k];
            end
        end
    end

`ifdef LAUNCH_PERF_CNT_EN
    logic [PW-1:0] n_issued, min_avail;

    assign n_issued  = PW'(popcnt(8'(out_valid_o)));
    assign min_avail = (count < PW'(ISSUE_W)) ? count : PW'(ISSUE_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_full_issue_cnt_o <= '0;
            perf_stall_cnt_o      <= '0;
        end else begin
            if (next_allowin_i && (&out_valid_o))
                perf_full_issue_cnt_o <= perf_full_issue_cnt_o + 32'd1;
            if (next_allowin_i && (count != '0) && (n_issued < min_avail))
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_issue_launch.sv
// Directed scoreboard bench for multi_issue_launch (ISSUE_W=2, DEPTH=8, PAYLOAD_W=64).
module tb_multi_issue_launch;
    import launch_pkg::*;

    localparam int IW = 2;
    localparam int EW = entry_w(64);
    typedef logic [EW-1:0] ent_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [IW-1:0]           in_valid;
    logic [IW-1:0][EW-1:0]   in_entry;
    logic                    in_ready;
    logic                    next_allowin;
    logic                    excep_flush;
    logic [IW-1:0]           out_valid;
    logic [IW-1:0][EW-1:0]   out_entry;
    logic                    jmp_flag;
    logic [31:0]             jmp_addr;

    int   vectors     = 0;
    int   miscompares = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    multi_issue_launch #(.ISSUE_W(IW), .DEPTH(8), .PAYLOAD_W(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid),
        .in_entry_i     (in_entry),
        .in_ready_o     (in_ready),
        .next_allowin_i (next_allowin),
        .excep_flush_i  (excep_flush),
        .out_valid_o    (out_valid),
        .out_entry_o    (out_entry),
        .jmp_flag_o     (jmp_flag),
        .jmp_addr_o     (jmp_addr)
    );

    function automatic ent_t mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                input logic re1, input logic [4:0] r1, input logic re2,
                                input logic [4:0] r2, input logic excl, input logic jmp,
                                input logic [31:0] ja);
        return {pc, ~pc, pc, we, wa, re1, r1, re2, r2, excl, jmp, ja};
    endfunction

    // independent entry: writes r16+i, reads only r1
    function automatic ent_t fent(input int i);
        return mk(32'h1c000100 + 32'(4 * i), 1'b1, 5'(16 + i), 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_e(input string tag, input ent_t obs, input ent_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input ent_t e0, input ent_t e1,
                         input logic allow, input logic fl);
        in_valid     = v;
        in_entry[0]  = e0;
        in_entry[1]  = e1;
        next_allowin = allow;
        excep_flush  = fl;
        #1;
    endtask

    task automatic pushn(input logic [1:0] v, input ent_t e0, input ent_t e1, input logic allow);
        drive(v, e0, e1, allow, 1'b0);
        if (v[0]) sb.push_back(e0);
        if (v[1]) sb.push_back(e1);
    endtask

    task automatic idle(input logic allow);
        drive(2'b00, '0, '0, allow, 1'b0);
    endtask

    task automatic check_issue(input string tag, input logic [1:0] mask, input bit pop);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mask));
        for (int k = 0; k < IW; k++) begin
            if (mask[k]) begin
                vectors++;
                assert (k < sb.size()) else begin
                    miscompares++;
                    $error("FAIL %s.sb: observed %0d queued expected more than %0d", tag, sb.size(), k);
                end
                if (k < sb.size()) chk_e($sformatf("%s.slot%0d", tag, k), out_entry[k], sb[k]);
            end
        end
        if (pop)
            for (int k = 0; k < IW; k++)
                if (mask[k] && sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic fill_pairs(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            pushn(2'b11, fent(base + 2 * i), fent(base + 2 * i + 1), 1'b0);
            cyc();
        end
    endtask

    task automatic drain_pairs(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            idle(1'b1);
            check_issue(tag, 2'b11, 1'b1);
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, '0, '0, 1'b0, 1'b0);
        #11;
        chk("rst.in_ready", 32'(in_ready), 32'h1);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.jmp_flag", 32'(jmp_flag), 32'h0);
        chk("rst.jmp_addr", jmp_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // independent pair issues together
        pushn(2'b11, mk(32'h1c000000, 1, 5'd3, 1, 5'd1, 1, 5'd2, 0, 0, 0),
                     mk(32'h1c000004, 1, 5'd5, 1, 5'd4, 1, 5'd6, 0, 0, 0), 1'b1);
        check_issue("t1.empty", 2'b00, 1'b0);
        cyc();
        idle(1'b1);
        check_issue("t1.pair", 2'b11, 1'b1);
        cyc();

        // RAW: sub r7<-r3,r1 waits for add r3
        pushn(2'b11, mk(32'h1c000008, 1, 5'd3, 1, 5'd1, 1, 5'd2, 0, 0, 0),
                     mk(32'h1c00000c, 1, 5'd7, 1, 5'd3, 1, 5'd1, 0, 0, 0), 1'b1);
        check_issue("t1.drained", 2'b00, 1'b0);
        cyc();
        idle(1'b1);
        check_issue("t2.raw", 2'b01, 1'b1);
        cyc();
        idle(1'b1);
        check_issue("t2.sub", 2'b01, 1'b1);
        cyc();

        // exclusive op only in slot 0
        pushn(2'b11, mk(32'h1c000010, 1, 5'd8, 1, 5'd1, 1, 5'd2, 0, 0, 0),
                     mk(32'h1c000014, 1, 5'd9, 1, 5'd10, 0, 5'd0, 1, 0, 0), 1'b1);
        check_issue("t2.drained", 2'b00, 1'b0);
        cyc();
        idle(1'b1);
        check_issue("t3.excl", 2'b01, 1'b1);
        cyc();
        idle(1'b1);
        check_issue("t3.ld", 2'b01, 1'b1);
        cyc();
        pushn(2'b11, mk(32'h1c000018, 1, 5'd14, 1, 5'd15, 0, 5'd0, 1, 0, 0),
                     mk(32'h1c00001c, 1, 5'd11, 1, 5'd12, 1, 5'd13, 0, 0, 0), 1'b1);
        cyc();
        idle(1'b1);
        check_issue("t3.ldadd", 2'b11, 1'b1);
        cyc();

        // taken branch with 4 buffered, stall hold first
        pushn(2'b11, mk(32'h1c000020, 0, 5'd0, 1, 5'd1, 1, 5'd2, 0, 1, 32'h1c000040),
                     fent(0), 1'b0);
        check_issue("t4.empty", 2'b00, 1'b0);
        cyc();
        pushn(2'b11, fent(1), fent(2), 1'b0);
        check_issue("t4.jmpblk", 2'b01, 1'b0);
        chk("t4.noflag", 32'(jmp_flag), 32'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check_issue($sformatf("t4.hold%0d", i), 2'b01, 1'b0);
            chk("t4.holdflag", 32'(jmp_flag), 32'h0);
            cyc();
        end
        drive(2'b11, fent(3), fent(4), 1'b1, 1'b0);
        chk("t4.ready", 32'(in_ready), 32'h1);
        check_issue("t4.branch", 2'b01, 1'b1);
        chk("t4.flag", 32'(jmp_flag), 32'h1);
        chk("t4.addr", jmp_addr, 32'h1c000040);
        sb.delete();
        cyc();
        idle(1'b1);
        check_issue("t4.after", 2'b00, 1'b0);
        chk("t4.flagoff", 32'(jmp_flag), 32'h0);

        // fill to 7, rejected push, drain
        fill_pairs(0, 3);
        pushn(2'b01, fent(6), '0, 1'b0);
        chk("t5.ready6", 32'(in_ready), 32'h1);
        cyc();
        drive(2'b11, fent(7), fent(8), 1'b0, 1'b0);
        chk("t5.full", 32'(in_ready), 32'h0);
        check_issue("t5.fullout", 2'b11, 1'b0);
        cyc();
        drain_pairs("t5.drain", 3);
        idle(1'b1);
        check_issue("t5.last", 2'b01, 1'b1);
        cyc();
        idle(1'b1);
        check_issue("t5.empty", 2'b00, 1'b0);
        chk("t5.ready0", 32'(in_ready), 32'h1);

        // exception flush with 6 entries and a pending push
        fill_pairs(9, 3);
        drive(2'b11, fent(0), fent(1), 1'b1, 1'b1);
        chk("t6.valid", 32'(out_valid), 32'h0);
        chk("t6.flag", 32'(jmp_flag), 32'h0);
        sb.delete();
        cyc();
        idle(1'b1);
        check_issue("t6.after", 2'b00, 1'b0);
        chk("t6.ready", 32'(in_ready), 32'h1);

        // move head to index 7, then push a pair straddling 7 -> 0
        pushn(2'b01, fent(15), '0, 1'b1);
        cyc();
        idle(1'b1);
        check_issue("t7.single", 2'b01, 1'b1);
        cyc();
        fill_pairs(0, 3);
        drain_pairs("t7.drain", 3);
        pushn(2'b11, mk(32'h1c000200, 1, 5'd2, 1, 5'd1, 0, 5'd0, 0, 0, 0),
                     mk(32'h1c000204, 1, 5'd3, 1, 5'd4, 0, 5'd0, 0, 0, 0), 1'b1);
        cyc();
        idle(1'b1);
        check_issue("t7.wrap", 2'b11, 1'b1);
        cyc();

        // asynchronous reset mid-stream
        pushn(2'b11, fent(2), fent(3), 1'b0);
        cyc();
        idle(1'b0);
        check_issue("t8.pre", 2'b11, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t8.valid", 32'(out_valid), 32'h0);
        chk("t8.ready", 32'(in_ready), 32'h1);
        chk("t8.flag", 32'(jmp_flag), 32'h0);
        chk("t8.addr", jmp_addr, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        check_issue("t8.after", 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
